// File: rtl/mem_lsu_axil.sv
// Load/store/fetch unit between a core and an AXI4-Lite memory.
// Stores are posted through a small FIFO; loads and fetches wait for it to drain.
module mem_lsu_axil #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned AW       = 32,
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [AW-1:0]     req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_err,
  output logic              sb_empty,
  output logic              wr_err,
  output logic [AW-1:0]     araddr,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [XLEN-1:0]   rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [AW-1:0]     awaddr,
  output logic [2:0]        awprot,
  output logic              awvalid,
  input  logic              awready,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN/8-1:0] wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);
  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned LW = $clog2(NB);
  localparam int unsigned PW = $clog2(SB_DEPTH);

  typedef enum logic [1:0] {RIdle, RAr, RR} r_state_e;
  typedef enum logic [1:0] {WIdle, WXfer, WResp} w_state_e;

  r_state_e r_state_q, r_state_d;
  w_state_e w_state_q, w_state_d;
  logic     aw_done_q, aw_done_d, w_done_q, w_done_d;

  logic [AW-1:0]   sb_addr [SB_DEPTH];
  logic [XLEN-1:0] sb_data [SB_DEPTH];
  logic [NB-1:0]   sb_strb [SB_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     count_q;
  logic            sb_full;

  logic [AW-1:0]   araddr_q;
  logic [2:0]      arprot_q;
  logic [LW-1:0]   lane_q;
  logic [1:0]      size_q;
  logic            sgn_q;
  logic            rsp_valid_q, rsp_err_q, wr_err_q;
  logic [XLEN-1:0] rsp_data_q;

  logic            is_store, is_fetch, bad, accept, push, pop;
  logic [1:0]      eff_size;
  logic [LW-1:0]   lane;
  logic [AW-1:0]   addr_al;
  logic [XLEN-1:0] st_data, shifted, ld_ext;
  logic [NB-1:0]   size_mask, st_strb;

  // Request decode
  assign is_store = (req_op == 2'b00);
  assign is_fetch = req_op[1];
  assign eff_size = is_fetch ? 2'b10 : req_size;
  assign lane     = req_addr[LW-1:0];
  assign addr_al  = req_addr & ~(AW'(NB - 1));

  always_comb begin
    case (eff_size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = req_addr[0];
      2'b10:   bad = |req_addr[1:0];
      default: bad = (XLEN != 64) || (|req_addr[2:0]);
    endcase
  end

  assign sb_full   = (count_q == (PW+1)'(SB_DEPTH));
  assign sb_empty  = (count_q == '0) && (w_state_q == WIdle);
  assign req_ready = (r_state_q == RIdle) && (is_store ? !sb_full : sb_empty);
  assign accept    = req_valid && req_ready;
  assign push      = accept && is_store && !bad;
  assign pop       = (w_state_q == WResp) && bvalid;

  // Replicate store data across every lane so the strobe alone selects bytes
  always_comb begin
    st_data = '0;
    for (int i = 0; i < NB; i++) begin
      case (eff_size)
        2'b00:   st_data[i*8 +: 8] = req_wdata[7:0];
        2'b01:   st_data[i*8 +: 8] = req_wdata[(i%2)*8 +: 8];
        2'b10:   st_data[i*8 +: 8] = req_wdata[(i%4)*8 +: 8];
        default: st_data[i*8 +: 8] = req_wdata[i*8 +: 8];
      endcase
    end
  end

  always_comb begin
    case (eff_size)
      2'b00:   size_mask = NB'(1);
      2'b01:   size_mask = NB'(3);
      2'b10:   size_mask = NB'(15);
      default: size_mask = '1;
    endcase
  end
  assign st_strb = size_mask << lane;

  assign shifted = rdata >> {lane_q, 3'b000};
  always_comb begin
    case (size_q)
      2'b00:   ld_ext = sgn_q ? XLEN'($signed(shifted[7:0]))  : XLEN'(shifted[7:0]);
      2'b01:   ld_ext = sgn_q ? XLEN'($signed(shifted[15:0])) : XLEN'(shifted[15:0]);
      2'b10:   ld_ext = sgn_q ? XLEN'($signed(shifted[31:0])) : XLEN'(shifted[31:0]);
      default: ld_ext = shifted;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      RIdle:   if (accept && !is_store && !bad) r_state_d = RAr;
      RAr:     if (arready) r_state_d = RR;
      RR:      if (rvalid) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  // AW and W complete independently; the response phase waits for both
  always_comb begin
    w_state_d = w_state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (w_state_q)
      WIdle: begin
        if (count_q != '0) begin
          w_state_d = WXfer;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WXfer: begin
        if (awready) aw_done_d = 1'b1;
        if (wready)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) w_state_d = WResp;
      end
      WResp:   if (bvalid) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  assign arvalid   = (r_state_q == RAr);
  assign rready    = (r_state_q == RR);
  assign araddr    = araddr_q;
  assign arprot    = arprot_q;
  assign awvalid   = (w_state_q == WXfer) && !aw_done_q;
  assign wvalid    = (w_state_q == WXfer) && !w_done_q;
  assign bready    = (w_state_q == WResp);
  assign awaddr    = sb_addr[rd_ptr_q];
  assign wdata     = sb_data[rd_ptr_q];
  assign wstrb     = sb_strb[rd_ptr_q];
  assign awprot    = 3'b000;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign wr_err    = wr_err_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state_q   <= RIdle;
      w_state_q   <= WIdle;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      araddr_q    <= '0;
      arprot_q    <= '0;
      lane_q      <= '0;
      size_q      <= '0;
      sgn_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      wr_err_q    <= 1'b0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_addr[i] <= '0;
        sb_data[i] <= '0;
        sb_strb[i] <= '0;
      end
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (push) begin
        sb_addr[wr_ptr_q] <= addr_al;
        sb_data[wr_ptr_q] <= st_data;
        sb_strb[wr_ptr_q] <= st_strb;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
      if (pop && (bresp != 2'b00)) wr_err_q <= 1'b1;

      rsp_valid_q <= 1'b0;
      if (accept && (is_store || bad)) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= bad;
        rsp_data_q  <= '0;
      end else if (accept) begin
        araddr_q <= addr_al;
        arprot_q <= is_fetch ? 3'b100 : 3'b000;
        lane_q   <= lane;
        size_q   <= eff_size;
        sgn_q    <= req_signed && !is_fetch;
      end
      if ((r_state_q == RR) && rvalid) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= (rresp != 2'b00);
        rsp_data_q  <= (rresp != 2'b00) ? '0 : ld_ext;
      end
    end
  end

endmodule
